// File: rtl/uart_tx_oversampled_pkg.sv
// Shared definitions for the 16x-oversampled UART transmitter and its
// companion receiver: FSM state encoding, oversampling ratio and a small
// helper for sizing counters.
package uart_tx_oversampled_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_e;

  // s_ticks per bit period; the receiver samples on the same ratio.
  localparam int unsigned OVERSAMPLE = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_oversampled.sv
// UART transmitter paced by a 16x baud enable (s_tick).
// Frame: one start bit (low), DBIT data bits LSB first, then a stop period of
// SB_TICK s_ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   tx_start     one-cycle request to send din; only honoured while idle
//   s_tick       one-cycle enable at 16x the baud rate
//   din          word to send, captured in the accepted tx_start cycle
//   tx_done_tick one-cycle pulse in the cycle the stop period completes
//   tx_busy      high whenever a frame is in progress
//   tx           registered serial output, idles high
module uart_tx_oversampled
  import uart_tx_oversampled_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic            s_tick,
  input  logic [DBIT-1:0] din,
  output logic            tx_done_tick,
  output logic            tx_busy,
  output logic            tx
);

  localparam int unsigned SW = max_u(4, $clog2(SB_TICK));
  localparam int unsigned NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  tx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    tx_done_tick = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          b_d     = din;
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            tx_done_tick = 1'b1;
            state_d      = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the *next* state so the registered tx
    // changes in the same cycle as the state, giving one cycle of latency
    // from an accepted tx_start to the start bit.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_busy = (state_q != IDLE);
  assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx_oversampled.sv
// Self-checking bench for uart_tx_oversampled. Two instances: the default
// 8N1 configuration and a 7-bit / 2-stop-bit configuration. A frame-level
// reference model (ticks elapsed since start -> bit index -> line level)
// checks every cycle; directed frames and hand-written corner sequences add
// explicit checks on top.
module tb_uart_tx_oversampled;

  localparam int TOT8 = 16 * (1 + 8) + 16;
  localparam int TOT7 = 16 * (1 + 7) + 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, tick8, start7, tick7;
  logic [7:0] din8;
  logic [6:0] din7;
  logic       done8, busy8, tx8;
  logic       done7, busy7, tx7;

  int n_chk   = 0;
  int n_fail  = 0;
  int n_done8 = 0;
  int n_done7 = 0;

  uart_tx_oversampled #(.DBIT(8), .SB_TICK(16)) u_dut8 (
    .clk(clk), .reset(reset), .tx_start(start8), .s_tick(tick8), .din(din8),
    .tx_done_tick(done8), .tx_busy(busy8), .tx(tx8)
  );

  uart_tx_oversampled #(.DBIT(7), .SB_TICK(32)) u_dut7 (
    .clk(clk), .reset(reset), .tx_start(start7), .s_tick(tick7), .din(din7),
    .tx_done_tick(done7), .tx_busy(busy7), .tx(tx7)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is just a count of s_ticks consumed since start.
  logic       m8_busy = 1'b0, m7_busy = 1'b0;
  int         m8_c = 0, m7_c = 0;
  logic [8:0] m8_word = '0, m7_word = '0;

  always @(posedge clk) begin
    if (reset) begin
      m8_busy <= 1'b0; m8_c <= 0;
      m7_busy <= 1'b0; m7_c <= 0;
    end else begin
      if (!m8_busy) begin
        if (start8) begin m8_busy <= 1'b1; m8_c <= 0; m8_word <= {1'b0, din8}; end
      end else if (tick8) begin
        if (m8_c == TOT8 - 1) m8_busy <= 1'b0; else m8_c <= m8_c + 1;
      end
      if (!m7_busy) begin
        if (start7) begin m7_busy <= 1'b1; m7_c <= 0; m7_word <= {2'b0, din7}; end
      end else if (tick7) begin
        if (m7_c == TOT7 - 1) m7_busy <= 1'b0; else m7_c <= m7_c + 1;
      end
    end
  end

  function automatic logic exp_level(input logic busy, input int c, input logic [8:0] word,
                                     input int dbit);
    int bn;
    if (!busy) return 1'b1;
    bn = c / 16;
    if (bn == 0) return 1'b0;
    if (bn <= dbit) return word[bn-1];
    return 1'b1;
  endfunction

  function automatic logic exp_done(input logic busy, input int c, input logic tick, input int tot);
    return busy && tick && (c == tot - 1);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no tx_done_tick within cycle budget (t=%0t)", name, $time);
  endtask

  // One clock cycle: drive on the falling edge, check the Mealy done output
  // mid-cycle, then check registered outputs just after the rising edge.
  task automatic step(input logic rst, input logic s8, input logic t8, input logic [7:0] d8,
                      input logic s7, input logic t7, input logic [6:0] d7,
                      output logic dn8, output logic dn7);
    @(negedge clk);
    reset = rst; start8 = s8; tick8 = t8; din8 = d8;
    start7 = s7; tick7 = t7; din7 = d7;
    #1;
    dn8 = done8;
    dn7 = done7;
    chk("done8", done8, exp_done(m8_busy, m8_c, t8, TOT8));
    chk("done7", done7, exp_done(m7_busy, m7_c, t7, TOT7));
    if (done8 === 1'b1) n_done8++;
    if (done7 === 1'b1) n_done7++;
    @(posedge clk);
    #1;
    chk("tx8", tx8, exp_level(m8_busy, m8_c, m8_word, 8));
    chk("busy8", busy8, m8_busy);
    chk("tx7", tx7, exp_level(m7_busy, m7_c, m7_word, 7));
    chk("busy7", busy7, m7_busy);
  endtask

  task automatic step8(input logic rst, input logic s, input logic t, input logic [7:0] d,
                       output logic dn);
    logic unused;
    step(rst, s, t, d, 1'b0, 1'b0, 7'h00, dn, unused);
  endtask

  task automatic step7(input logic s, input logic t, input logic [6:0] d, output logic dn);
    logic unused;
    step(1'b0, 1'b0, 1'b0, 8'h00, s, t, d, unused, dn);
  endtask

  // Send one frame on the 8-bit instance. Ticks arrive every p cycles counted
  // from the start cycle; a second tx_start with din=FF is pulsed at cycle rep.
  // The line is decoded at the middle of each 16-tick bit, as a receiver would.
  task automatic run_frame8(input logic [7:0] d, input int p, input int rep,
                            output int done_cyc, output logic [7:0] dec);
    logic dn;
    int   k;
    int   m;
    done_cyc = -1;
    dec      = '0;
    step8(1'b0, 1'b1, (p == 1), d, dn);
    chk("tx_low_after_start", tx8, 1'b0);
    k = 0;
    while (done_cyc < 0 && k < 200 * p + 20) begin
      k++;
      step8(1'b0, (k == rep), ((k % p) == 0), (k == rep) ? 8'hFF : d, dn);
      if (dn === 1'b1) done_cyc = k;
      m = k + 1;  // the level just sampled is the one held during cycle m
      if (m == 8 * p) chk("start_bit_mid", tx8, 1'b0);
      for (int b = 1; b <= 8; b++)
        if (m == 16 * p * b + 8 * p) dec[b-1] = tx8;
      if (m == 16 * p * 9 + 8 * p) chk("stop_bit_mid", tx8, 1'b1);
    end
    if (done_cyc < 0) timeout("frame8");
  endtask

  typedef struct {
    logic [7:0] din;
    int         p;
    int         rep;
    int         exp_done;
    logic [7:0] exp_word;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         dc, dc2, c0, k, m;
    logic [7:0] dec, dec2;
    logic [6:0] dec7;
    logic       dn, dn7, prev_busy;

    vecs[0] = '{din: 8'hA5, p: 1,  rep: 0,  exp_done: 160,  exp_word: 8'hA5};
    vecs[1] = '{din: 8'h3C, p: 10, rep: 0,  exp_done: 1600, exp_word: 8'h3C};
    vecs[2] = '{din: 8'h5A, p: 3,  rep: 0,  exp_done: 480,  exp_word: 8'h5A};
    vecs[3] = '{din: 8'hC3, p: 1,  rep: 64, exp_done: 160,  exp_word: 8'hC3};
    vecs[4] = '{din: 8'h01, p: 2,  rep: 0,  exp_done: 320,  exp_word: 8'h01};

    reset = 1'b1; start8 = 1'b0; tick8 = 1'b0; din8 = '0;
    start7 = 1'b0; tick7 = 1'b0; din7 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx8", tx8, 1'b1);
    chk("reset_busy8", busy8, 1'b0);
    chk("reset_done8", done8, 1'b0);
    chk("reset_tx7", tx7, 1'b1);
    chk("reset_busy7", busy7, 1'b0);
    chk("reset_done7", done7, 1'b0);
    repeat (2) step8(1'b0, 1'b0, 1'b1, 8'h00, dn);

    // Directed frames from the vector table.
    for (int i = 0; i < 5; i++) begin
      c0 = n_done8;
      run_frame8(vecs[i].din, vecs[i].p, vecs[i].rep, dc, dec);
      chk_i($sformatf("vec%0d_done_cycle", i), dc, vecs[i].exp_done);
      chk_i($sformatf("vec%0d_word", i), int'(dec), int'(vecs[i].exp_word));
      repeat (3) step8(1'b0, 1'b0, 1'b1, 8'h00, dn);
      chk_i($sformatf("vec%0d_done_count", i), n_done8 - c0, 1);
    end

    // tx_start in the done cycle is dropped; the one right after is taken.
    c0 = n_done8;
    run_frame8(8'h96, 1, 160, dc, dec);
    chk("idle_after_done_tx", tx8, 1'b1);
    chk("idle_after_done_busy", busy8, 1'b0);
    run_frame8(8'h00, 1, 0, dc2, dec2);
    chk_i("b2b_first_done", dc, 160);
    chk_i("b2b_first_word", int'(dec), 8'h96);
    chk_i("b2b_second_done", dc2, 160);
    chk_i("b2b_second_word", int'(dec2), 8'h00);
    chk_i("b2b_done_count", n_done8 - c0, 2);
    repeat (3) step8(1'b0, 1'b0, 1'b1, 8'h00, dn);

    // Reset held three cycles in the middle of the data bits.
    c0 = n_done8;
    step8(1'b0, 1'b1, 1'b1, 8'hA5, dn);
    repeat (60) step8(1'b0, 1'b0, 1'b1, 8'hA5, dn);
    chk("pre_reset_busy", busy8, 1'b1);
    repeat (3) step8(1'b1, 1'b0, 1'b1, 8'hA5, dn);
    step8(1'b0, 1'b0, 1'b1, 8'hA5, dn);
    chk("post_reset_tx", tx8, 1'b1);
    chk("post_reset_busy", busy8, 1'b0);
    chk("post_reset_done", done8, 1'b0);
    repeat (40) step8(1'b0, 1'b0, 1'b1, 8'hA5, dn);
    chk("post_reset_tx_quiet", tx8, 1'b1);
    chk_i("post_reset_done_count", n_done8 - c0, 0);

    // 7 data bits, two stop bits; din changes mid-frame must not matter.
    c0 = n_done7;
    dc = -1;
    dec7 = '0;
    step7(1'b1, 1'b1, 7'h55, dn7);
    chk("tx7_low_after_start", tx7, 1'b0);
    prev_busy = busy7;
    k = 0;
    while (dc < 0 && k < 220) begin
      k++;
      step7(1'b0, 1'b1, 7'h2A, dn7);
      m = k + 1;
      if (dn7 === 1'b1) begin
        dc = k;
        chk("busy7_during_done", prev_busy, 1'b1);
        chk("busy7_after_done", busy7, 1'b0);
      end
      for (int b = 1; b <= 7; b++)
        if (m == 16 * b + 8) dec7[b-1] = tx7;
      if (m == 136 || m == 152 || m == 160) chk($sformatf("tx7_stop_c%0d", m), tx7, 1'b1);
      prev_busy = busy7;
    end
    if (dc < 0) timeout("frame7");
    chk_i("frame7_done_cycle", dc, 160);
    chk_i("frame7_word", int'(dec7), 7'h55);
    repeat (3) step7(1'b0, 1'b1, 7'h00, dn7);
    chk_i("frame7_done_count", n_done7 - c0, 1);

    // Random traffic on both instances, judged by the reference model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 599) == 0),
           ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)), 7'($urandom),
           dn, dn7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
